// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes,
// the bundled stall/flush control vector, the NOP instruction word and a
// state decode helper used by the controller.
package pipe_hazard_ctrl_pkg;

    // FSM state encodings (value 3 is never entered and decodes as RUN)
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    // Default register-address width of the RV32I register file (x0..x31)
    localparam int REG_AW_DEF = 5;

    // Canonical NOP (addi x0, x0, 0) loaded into F/D on a flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Stall/flush enables produced in one cycle
    typedef struct packed {
        logic pc_hold;
        logic fd_hold;
        logic fd_flush;
        logic de_hold;
        logic de_bubble;
        logic pc_redirect;
    } hazard_ctrl_t;

    // Width of the control vector above
    localparam int CTRL_VEC_W = $bits(hazard_ctrl_t);

    // Map a raw state register value onto a legal state; the unused code 3 acts as RUN
    function automatic logic [1:0] decode_state(input logic [1:0] raw);
        logic [1:0] legal;
        legal = ST_RUN;
        if (raw == ST_FLUSH || raw == ST_MEM_WAIT) begin
            legal = raw;
        end
        return legal;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of the decode/execute hazard inputs and the stall/flush outputs of
// the pipeline hazard controller. The pipeline side uses the master modport,
// the controller uses the slave modport.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);

    // Hazard sources presented by the pipeline
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_redirect;
    logic              mem_busy;

    // Stage enables returned to the pipeline
    logic              pc_hold;
    logic              fd_hold;
    logic              fd_flush;
    logic              de_hold;
    logic              de_bubble;
    logic              pc_redirect;

    // Debug and performance observation
    logic [1:0]        ctrl_state;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rd, ex_mem_read, ex_redirect, mem_busy,
        input  pc_hold, fd_hold, fd_flush, de_hold, de_bubble, pc_redirect,
               ctrl_state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rd, ex_mem_read, ex_redirect, mem_busy,
        output pc_hold, fd_hold, fd_flush, de_hold, de_bubble, pc_redirect,
               ctrl_state, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: saturating event counter with synchronous clear.
// Used twice by pipe_hazard_ctrl when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    // Count events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
// Generates hold/bubble/flush enables for PC, F/D and D/E from load-use
// hazards, EX redirects and data-memory back-pressure.
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush
// performance counters; otherwise both counter outputs are tied to zero.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int REDIRECT_LAT = 1,
    parameter int CNT_W        = 32
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    // Number of extra F/D flush cycles after the redirect cycle itself
    localparam logic [2:0]        LAT_CYC = 3'(REDIRECT_LAT);
    localparam logic [REG_AW-1:0] REG_X0  = '0;

    logic [1:0]   state;
    logic [1:0]   next_state;
    logic [1:0]   saved_state;
    logic [1:0]   next_saved;
    logic [2:0]   flush_ctr;
    logic [2:0]   next_flush_ctr;
    logic [1:0]   eff_state;
    logic         load_use;
    hazard_ctrl_t ctrl;

    // A load in EX whose destination is read by the valid instruction in decode; x0 never stalls
    always_comb begin
        load_use = bus.id_valid && bus.ex_mem_read && (bus.ex_rd != REG_X0) &&
                   ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                    (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));
    end

    // Decide this cycle's enables and the next state; leaving MEM_WAIT behaves like the saved state
    always_comb begin
        ctrl           = '0;
        next_state     = state;
        next_saved     = saved_state;
        next_flush_ctr = flush_ctr;
        eff_state      = decode_state(state);
        if (eff_state == ST_MEM_WAIT && !bus.mem_busy) begin
            eff_state = decode_state(saved_state);
        end

        if (rst) begin
            ctrl.fd_flush  = 1'b1;
            ctrl.de_bubble = 1'b1;
        end else if (bus.mem_busy) begin
            ctrl.pc_hold = 1'b1;
            ctrl.fd_hold = 1'b1;
            ctrl.de_hold = 1'b1;
            next_state   = ST_MEM_WAIT;
            if (eff_state != ST_MEM_WAIT) begin
                next_saved = eff_state;
            end
        end else begin
            case (eff_state)
                ST_FLUSH: begin
                    ctrl.fd_flush  = 1'b1;
                    ctrl.de_bubble = 1'b1;
                    if (flush_ctr <= 3'd1) begin
                        next_state     = ST_RUN;
                        next_flush_ctr = 3'd0;
                    end else begin
                        next_state     = ST_FLUSH;
                        next_flush_ctr = flush_ctr - 3'd1;
                    end
                end
                default: begin
                    next_state = ST_RUN;
                    if (bus.ex_redirect) begin
                        ctrl.pc_redirect = 1'b1;
                        ctrl.fd_flush    = 1'b1;
                        ctrl.de_bubble   = 1'b1;
                        next_flush_ctr   = LAT_CYC;
                        if (LAT_CYC != 3'd0) begin
                            next_state = ST_FLUSH;
                        end
                    end else if (load_use) begin
                        ctrl.pc_hold   = 1'b1;
                        ctrl.fd_hold   = 1'b1;
                        ctrl.de_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    // State, saved return state and remaining flush cycles; reset returns straight to RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            saved_state <= ST_RUN;
            flush_ctr   <= 3'd0;
        end else begin
            state       <= next_state;
            saved_state <= next_saved;
            flush_ctr   <= next_flush_ctr;
        end
    end

    assign bus.pc_hold     = ctrl.pc_hold;
    assign bus.fd_hold     = ctrl.fd_hold;
    assign bus.fd_flush    = ctrl.fd_flush;
    assign bus.de_hold     = ctrl.de_hold;
    assign bus.de_bubble   = ctrl.de_bubble;
    assign bus.pc_redirect = ctrl.pc_redirect;
    assign bus.ctrl_state  = rst ? ST_RUN : state;

`ifdef HAZARD_PERF_CNT_EN
    // pc_hold is raised only by a load-use stall or a memory hold, pc_redirect only by an accepted redirect
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (ctrl.pc_hold),
        .cnt (bus.stall_cnt)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .inc (ctrl.pc_redirect),
        .cnt (bus.flush_cnt)
    );
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int LAT    = 1;
    localparam int CNT_W  = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       busy;
    } stim_t;

    logic clk = 1'b0;
    logic rst;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model: remaining post-redirect flush cycles, whether the last cycle was a memory hold, counts
    int               flush_left = 0;
    bit               prev_busy  = 1'b0;
    logic [CNT_W-1:0] m_stall    = '0;
    logic [CNT_W-1:0] m_flush    = '0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .REG_AW       (REG_AW),
        .REDIRECT_LAT (LAT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wire [7:0] obs_ctl = {bus.pc_hold, bus.fd_hold, bus.fd_flush, bus.de_hold,
                          bus.de_bubble, bus.pc_redirect, bus.ctrl_state};
    wire [2*CNT_W-1:0] obs_cnt = {bus.stall_cnt, bus.flush_cnt};

    function automatic stim_t mk(input logic r, input logic v, input int rs1, input int rs2,
                                 input logic u1, input logic u2, input int rd,
                                 input logic mr, input logic redir, input logic busy);
        stim_t s;
        s.rst = r; s.valid = v; s.rs1 = 5'(rs1); s.rs2 = 5'(rs2);
        s.u1 = u1; s.u2 = u2; s.rd = 5'(rd); s.mr = mr; s.redir = redir; s.busy = busy;
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Drive one cycle of inputs mid-cycle and advance the reference model by that cycle
    task automatic applyStimulus(input stim_t s, output logic [7:0] e_ctl,
                                 output logic [2*CNT_W-1:0] e_cnt);
        logic       lu;
        logic [1:0] e_state;
        @(negedge clk);
        rst             = s.rst;
        bus.id_valid    = s.valid;
        bus.id_rs1      = s.rs1;
        bus.id_rs2      = s.rs2;
        bus.id_rs1_used = s.u1;
        bus.id_rs2_used = s.u2;
        bus.ex_rd       = s.rd;
        bus.ex_mem_read = s.mr;
        bus.ex_redirect = s.redir;
        bus.mem_busy    = s.busy;
        #2;
        e_cnt   = PERF ? {m_stall, m_flush} : '0;
        lu      = s.valid && s.mr && (s.rd != 0) &&
                  ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        e_state = prev_busy ? 2'd2 : ((flush_left > 0) ? 2'd1 : 2'd0);
        if (s.rst) begin
            e_ctl      = {6'b001010, 2'd0};
            flush_left = 0;
            prev_busy  = 1'b0;
            m_stall    = '0;
            m_flush    = '0;
        end else if (s.busy) begin
            e_ctl     = {6'b110100, e_state};
            m_stall   = sat_inc(m_stall);
            prev_busy = 1'b1;
        end else begin
            prev_busy = 1'b0;
            if (flush_left > 0) begin
                e_ctl      = {6'b001010, e_state};
                flush_left = flush_left - 1;
            end else if (s.redir) begin
                e_ctl      = {6'b001011, e_state};
                flush_left = LAT;
                m_flush    = sat_inc(m_flush);
            end else if (lu) begin
                e_ctl   = {6'b110010, e_state};
                m_stall = sat_inc(m_stall);
            end else begin
                e_ctl = {6'b000000, e_state};
            end
        end
    endtask

    task automatic test_reset();
        stim_t s [0:2];
        logic [7:0] e_ctl;
        logic [2*CNT_W-1:0] e_cnt;
        s = '{mk(1,1,3,3,1,1,3,1,1,1), mk(1,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s[i], e_ctl, e_cnt);
            checks_total++;
            if (obs_ctl !== e_ctl) $display("[TB] FAIL reset_ctl step%0d got %b expected %b", i, obs_ctl, e_ctl);
            else checks_passed++;
            checks_total++;
            if (obs_cnt !== e_cnt) $display("[TB] FAIL reset_cnt step%0d got %h expected %h", i, obs_cnt, e_cnt);
            else checks_passed++;
        end
    endtask

    task automatic test_load_use();
        stim_t s [0:6];
        logic [7:0] e_ctl;
        logic [2*CNT_W-1:0] e_cnt;
        s = '{mk(0,1,0,5,0,1,5,1,0,0), mk(0,1,0,5,0,1,0,1,0,0), mk(0,1,7,0,0,0,7,1,0,0),
              mk(0,0,7,0,1,0,7,1,0,0), mk(0,1,7,0,1,0,7,1,0,0), mk(0,1,0,0,1,1,0,1,0,0),
              mk(0,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(s[i], e_ctl, e_cnt);
            checks_total++;
            if (obs_ctl !== e_ctl) $display("[TB] FAIL load_use_ctl step%0d got %b expected %b", i, obs_ctl, e_ctl);
            else checks_passed++;
            checks_total++;
            if (obs_cnt !== e_cnt) $display("[TB] FAIL load_use_cnt step%0d got %h expected %h", i, obs_cnt, e_cnt);
            else checks_passed++;
        end
    endtask

    task automatic test_redirect();
        stim_t s [0:4];
        logic [7:0] e_ctl;
        logic [2*CNT_W-1:0] e_cnt;
        s = '{mk(0,0,0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0),
              mk(0,1,4,4,1,1,4,1,1,0), mk(0,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(s[i], e_ctl, e_cnt);
            checks_total++;
            if (obs_ctl !== e_ctl) $display("[TB] FAIL redirect_ctl step%0d got %b expected %b", i, obs_ctl, e_ctl);
            else checks_passed++;
            checks_total++;
            if (obs_cnt !== e_cnt) $display("[TB] FAIL redirect_cnt step%0d got %h expected %h", i, obs_cnt, e_cnt);
            else checks_passed++;
        end
    endtask

    task automatic test_busy_in_flush();
        stim_t s [0:6];
        logic [7:0] e_ctl;
        logic [2*CNT_W-1:0] e_cnt;
        s = '{mk(0,0,0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,0,0,0,1), mk(0,0,0,0,0,0,0,0,0,1),
              mk(0,0,0,0,0,0,0,0,0,1), mk(0,0,0,0,0,0,0,0,0,0), mk(0,1,2,0,1,0,2,1,0,0),
              mk(0,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(s[i], e_ctl, e_cnt);
            checks_total++;
            if (obs_ctl !== e_ctl) $display("[TB] FAIL busy_flush_ctl step%0d got %b expected %b", i, obs_ctl, e_ctl);
            else checks_passed++;
            checks_total++;
            if (obs_cnt !== e_cnt) $display("[TB] FAIL busy_flush_cnt step%0d got %h expected %h", i, obs_cnt, e_cnt);
            else checks_passed++;
        end
    endtask

    task automatic test_reset_in_mem_wait();
        stim_t s [0:4];
        logic [7:0] e_ctl;
        logic [2*CNT_W-1:0] e_cnt;
        s = '{mk(0,0,0,0,0,0,0,0,0,1), mk(0,0,0,0,0,0,0,0,0,1), mk(1,0,0,0,0,0,0,0,0,1),
              mk(0,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(s[i], e_ctl, e_cnt);
            checks_total++;
            if (obs_ctl !== e_ctl) $display("[TB] FAIL rst_memwait_ctl step%0d got %b expected %b", i, obs_ctl, e_ctl);
            else checks_passed++;
            checks_total++;
            if (obs_cnt !== e_cnt) $display("[TB] FAIL rst_memwait_cnt step%0d got %h expected %h", i, obs_cnt, e_cnt);
            else checks_passed++;
        end
    endtask

    task automatic test_random();
        stim_t s;
        logic [7:0] e_ctl;
        logic [2*CNT_W-1:0] e_cnt;
        for (int i = 0; i < 400; i++) begin
            s.rst   = ($urandom_range(0, 63) == 0);
            s.valid = ($urandom_range(0, 3) != 0);
            s.rs1   = 5'($urandom_range(0, 7));
            s.rs2   = 5'($urandom_range(0, 7));
            s.u1    = 1'($urandom_range(0, 1));
            s.u2    = 1'($urandom_range(0, 1));
            s.rd    = 5'($urandom_range(0, 7));
            s.mr    = 1'($urandom_range(0, 1));
            s.redir = ($urandom_range(0, 5) == 0);
            s.busy  = ($urandom_range(0, 4) == 0);
            applyStimulus(s, e_ctl, e_cnt);
            checks_total++;
            if (obs_ctl !== e_ctl) $display("[TB] FAIL random_ctl cyc%0d got %b expected %b", i, obs_ctl, e_ctl);
            else checks_passed++;
            checks_total++;
            if (obs_cnt !== e_cnt) $display("[TB] FAIL random_cnt cyc%0d got %h expected %h", i, obs_cnt, e_cnt);
            else checks_passed++;
        end
    endtask

    // Bring the DUT out of power-up with a clean reset, then run every scenario in turn
    initial begin
        rst             = 1'b1;
        bus.id_valid    = 1'b0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rs1_used = 1'b0;
        bus.id_rs2_used = 1'b0;
        bus.ex_rd       = '0;
        bus.ex_mem_read = 1'b0;
        bus.ex_redirect = 1'b0;
        bus.mem_busy    = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_load_use();
        test_redirect();
        test_busy_in_flush();
        test_reset_in_mem_wait();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
